// File: rtl/fpu_seq_pkg.sv
// Shared types for the fpu command sequencer: opcodes, FSM states, the queued
// command record and the bit positions inside the fpu flag byte.
package fpu_seq_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_MUL  = 3'b010,
    OP_DIV  = 3'b011,
    OP_LOAD = 3'b100
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LD_EN  = 3'd1,
    S_LD_WR  = 3'd2,
    S_OP_RUN = 3'd3,
    S_RSP    = 3'd4,
    S_GAP    = 3'd5
  } state_e;

  // op is kept as raw bits so illegal encodings can sit in the FIFO until dropped
  typedef struct packed {
    logic [2:0]        op;
    logic [4:0]        src1;
    logic [4:0]        src2;
    logic [4:0]        dst;
    logic [DATA_W-1:0] data;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  localparam int FLAG_LESS     = 0;
  localparam int FLAG_GREAT    = 1;
  localparam int FLAG_EQ       = 2;
  localparam int FLAG_INEXACT  = 3;
  localparam int FLAG_DIV_ZERO = 4;
  localparam int FLAG_INV      = 5;
  localparam int FLAG_UN       = 6;
  localparam int FLAG_OV       = 7;

  function automatic logic is_arith(input logic [2:0] op);
    return op inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV};
  endfunction

endpackage

// File: rtl/fpu_seq_fifo.sv
// Synchronous command FIFO; read/write pointers carry one extra wrap bit so
// full and empty are told apart without a separate occupancy counter.
module fpu_seq_fifo
  import fpu_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstp,
  input  logic             push,
  input  logic [CMD_W-1:0] push_data,
  input  logic             pop,
  output logic [CMD_W-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  cmd_t          mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rstp) begin
    if (!rstp) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Storage needs no reset: entries are only ever read between the pointers
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr[AW-1:0]] <= cmd_t'(push_data);
    end
  end

endmodule

// File: rtl/fpu_cmd_sequencer.sv
// Command front-end for the fpu: queues load/arith commands and drives the fpu
// pins with registered timing. Optional watchdog: define FPU_SEQ_TIMEOUT_EN.
module fpu_cmd_sequencer
  import fpu_seq_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clk,
  input  logic             rstp,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [4:0]       cmd_src1,
  input  logic [4:0]       cmd_src2,
  input  logic [4:0]       cmd_dst,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [7:0]       rsp_flags,
  output logic             rsp_timeout,
  output logic             busy,
  output logic             fpu_enable,
  output logic             fpu_ld,
  output logic [2:0]       fpu_opcode,
  output logic [4:0]       fpu_addr1,
  output logic [4:0]       fpu_addr2,
  output logic [4:0]       fpu_addr3,
  output logic [WIDTH-1:0] fpu_inp,
  input  logic [WIDTH-1:0] fpu_out,
  input  logic [7:0]       fpu_flags,
  input  logic             fpu_done
);

  state_e             state_q, state_d;
  cmd_t               cur_q, cur_d, head;
  logic [CMD_W-1:0]   head_bits;
  logic               fifo_full, fifo_empty;
  logic               push, pop, capture, timed_out;
  logic               en_d, ld_d;
  logic [2:0]         opc_d;
  logic [4:0]         a1_d, a2_d, a3_d;
  logic [WIDTH-1:0]   inp_d;

  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && !fifo_full;
  assign head      = cmd_t'(head_bits);
  assign busy      = (state_q != S_IDLE) || !fifo_empty;

  fpu_seq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstp      (rstp),
    .push      (push),
    .push_data ({cmd_op, cmd_src1, cmd_src2, cmd_dst, DATA_W'(cmd_data)}),
    .pop       (pop),
    .pop_data  (head_bits),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef FPU_SEQ_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] wd_cnt;
  logic             rsp_timeout_q;

  // Counter reads 0 on the first OP_RUN cycle, so the abort lands after TIMEOUT_CYC cycles
  always_ff @(posedge clk or negedge rstp) begin
    if (!rstp) begin
      wd_cnt        <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      if (state_q == S_OP_RUN) begin
        wd_cnt <= wd_cnt + 1'b1;
      end else begin
        wd_cnt <= '0;
      end
      if (capture) begin
        rsp_timeout_q <= 1'b0;
      end else if (timed_out) begin
        rsp_timeout_q <= 1'b1;
      end
    end
  end

  assign timed_out   = (state_q == S_OP_RUN) && !fpu_done &&
                       (wd_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign rsp_timeout = rsp_timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
  assign timed_out          = 1'b0;
  assign rsp_timeout        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    pop     = 1'b0;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Illegal opcodes are popped here and simply never leave IDLE
        if (!fifo_empty) begin
          pop   = 1'b1;
          cur_d = head;
          if (head.op == OP_LOAD) begin
            state_d = S_LD_EN;
          end else if (is_arith(head.op)) begin
            state_d = S_OP_RUN;
          end
        end
      end
      S_LD_EN:  state_d = S_LD_WR;
      S_LD_WR:  state_d = S_GAP;
      S_OP_RUN: begin
        if (fpu_done) begin
          capture = 1'b1;
          state_d = S_RSP;
        end else if (timed_out) begin
          state_d = S_RSP;
        end
      end
      S_RSP: begin
        if (rsp_ready) begin
          state_d = S_GAP;
        end
      end
      S_GAP:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Pin values are derived from the next state so they can be registered
    en_d  = 1'b0;
    ld_d  = 1'b0;
    opc_d = '0;
    a1_d  = '0;
    a2_d  = '0;
    a3_d  = '0;
    inp_d = '0;
    case (state_d)
      S_LD_EN, S_LD_WR: begin
        en_d  = 1'b1;
        ld_d  = (state_d == S_LD_WR);
        opc_d = OP_LOAD;
        a1_d  = cur_d.src1;
        inp_d = WIDTH'(cur_d.data);
      end
      S_OP_RUN: begin
        en_d  = 1'b1;
        opc_d = cur_d.op;
        a1_d  = cur_d.src1;
        a2_d  = cur_d.src2;
        a3_d  = cur_d.dst;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstp) begin
    if (!rstp) begin
      state_q    <= S_IDLE;
      cur_q      <= '0;
      fpu_enable <= 1'b0;
      fpu_ld     <= 1'b0;
      fpu_opcode <= '0;
      fpu_addr1  <= '0;
      fpu_addr2  <= '0;
      fpu_addr3  <= '0;
      fpu_inp    <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_flags  <= '0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      fpu_enable <= en_d;
      fpu_ld     <= ld_d;
      fpu_opcode <= opc_d;
      fpu_addr1  <= a1_d;
      fpu_addr2  <= a2_d;
      fpu_addr3  <= a3_d;
      fpu_inp    <= inp_d;
      rsp_valid  <= (state_d == S_RSP);
      if (capture) begin
        rsp_data  <= fpu_out;
        rsp_flags <= fpu_flags;
      end else if (timed_out) begin
        rsp_data  <= '0;
        rsp_flags <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fpu_cmd_sequencer.sv
// Bench for fpu_cmd_sequencer: stub fpu, command-level reference model with a
// per-cycle compare process, and directed scenarios with literal expectations.
module tb_fpu_cmd_sequencer;
  import fpu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rstp = 1'b0;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_op;
  logic [4:0]  cmd_src1, cmd_src2, cmd_dst;
  logic [31:0] cmd_data;
  logic        rsp_valid, rsp_ready, rsp_timeout, busy;
  logic [31:0] rsp_data;
  logic [7:0]  rsp_flags;
  logic        fpu_enable, fpu_ld, fpu_done;
  logic [2:0]  fpu_opcode;
  logic [4:0]  fpu_addr1, fpu_addr2, fpu_addr3;
  logic [31:0] fpu_inp, fpu_out;
  logic [7:0]  fpu_flags;

  always #5 clk = ~clk;

  fpu_cmd_sequencer #(.WIDTH(32), .DEPTH(4), .TIMEOUT_CYC(64)) dut (
    .clk(clk), .rstp(rstp),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_src1(cmd_src1), .cmd_src2(cmd_src2), .cmd_dst(cmd_dst), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_flags(rsp_flags), .rsp_timeout(rsp_timeout), .busy(busy),
    .fpu_enable(fpu_enable), .fpu_ld(fpu_ld), .fpu_opcode(fpu_opcode),
    .fpu_addr1(fpu_addr1), .fpu_addr2(fpu_addr2), .fpu_addr3(fpu_addr3),
    .fpu_inp(fpu_inp), .fpu_out(fpu_out), .fpu_flags(fpu_flags), .fpu_done(fpu_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Arithmetic of the stub fpu; only the 1.0+2.0 case is real floating point
  function automatic void fpuCompute(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] res, output logic [7:0] fl);
    fl = 8'h00;
    case (op)
      3'b000:  res = (a == 32'h3F800000 && b == 32'h40000000) ? 32'h40400000 : a + b;
      3'b001:  res = a - b;
      3'b010:  res = a * b;
      3'b011: begin
        if (b == 32'h0) begin
          res = 32'h7F800000;
          fl[FLAG_DIV_ZERO] = 1'b1;
        end else begin
          res = a / b;
        end
      end
      default: res = 32'h0;
    endcase
  endfunction

  // Stub fpu: writes on enable&ld, answers an operation after three enabled cycles
  logic [31:0] stub_regs [32];
  logic        fpu_mute = 1'b0;
  int          op_cnt;
  logic        done_sent;

  always @(posedge clk or negedge rstp) begin
    logic [31:0] r;
    logic [7:0]  f;
    if (!rstp) begin
      fpu_done  <= 1'b0;
      fpu_out   <= '0;
      fpu_flags <= '0;
      op_cnt    <= 0;
      done_sent <= 1'b0;
      for (int i = 0; i < 32; i++) stub_regs[i] <= '0;
    end else begin
      fpu_done <= 1'b0;
      if (fpu_enable && fpu_ld) stub_regs[fpu_addr1] <= fpu_inp;
      if (fpu_enable && !fpu_ld && fpu_opcode != 3'b100) begin
        if (!done_sent && !fpu_mute) begin
          if (op_cnt == 2) begin
            fpuCompute(fpu_opcode, stub_regs[fpu_addr1], stub_regs[fpu_addr2], r, f);
            fpu_done  <= 1'b1;
            fpu_out   <= r;
            fpu_flags <= f;
            stub_regs[fpu_addr3] <= r;
            done_sent <= 1'b1;
          end else begin
            op_cnt <= op_cnt + 1;
          end
        end
      end else begin
        op_cnt    <= 0;
        done_sent <= 1'b0;
      end
    end
  end

  // Reference model: every accepted command yields an expected fpu issue and,
  // for arithmetic, an expected response computed from the model register file
  typedef struct { logic [2:0] op; logic [4:0] a1, a2, a3; logic [31:0] inp; } issue_t;
  typedef struct { logic [31:0] data; logic [7:0] flags; logic tmo; } rsp_t;

  issue_t      issue_q [$];
  rsp_t        rsp_q [$];
  logic [31:0] model_regs [32];
  logic        expect_timeout = 1'b0;
  int          issue_count = 0, rsp_count = 0, accept_count = 0;
  logic [31:0] last_rsp_data;
  logic [7:0]  last_rsp_flags;
  logic        prev_en, prev_ld, prev_rsp_valid, prev_rsp_ready, prev_tmo;
  logic [2:0]  prev_opc;
  logic [4:0]  prev_a1;
  logic [31:0] prev_inp, prev_rsp_data;
  logic [7:0]  prev_rsp_flags;

  always @(negedge clk) begin
    issue_t      ei;
    rsp_t        er;
    logic [31:0] r;
    logic [7:0]  f;
    if (!rstp) begin
      issue_q.delete();
      rsp_q.delete();
      for (int i = 0; i < 32; i++) model_regs[i] = '0;
      prev_en = 1'b0; prev_ld = 1'b0; prev_opc = '0; prev_a1 = '0; prev_inp = '0;
      prev_rsp_valid = 1'b0; prev_rsp_ready = 1'b0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        accept_count++;
        if (cmd_op == 3'b100) begin
          issue_q.push_back('{3'b100, cmd_src1, 5'd0, 5'd0, cmd_data});
          model_regs[cmd_src1] = cmd_data;
        end else if (cmd_op <= 3'b011) begin
          issue_q.push_back('{cmd_op, cmd_src1, cmd_src2, cmd_dst, 32'h0});
          if (expect_timeout) begin
            rsp_q.push_back('{32'h0, 8'h00, 1'b1});
          end else begin
            fpuCompute(cmd_op, model_regs[cmd_src1], model_regs[cmd_src2], r, f);
            rsp_q.push_back('{r, f, 1'b0});
            model_regs[cmd_dst] = r;
          end
        end
      end
      if (fpu_enable && !prev_en) begin
        issue_count++;
        if (issue_q.size() == 0) begin
          checkOutput("unexpected_issue", 64'd1, 64'd0);
        end else begin
          ei = issue_q.pop_front();
          checkOutput("issue_opcode", fpu_opcode, ei.op);
          checkOutput("issue_addr1", fpu_addr1, ei.a1);
          if (ei.op == 3'b100) begin
            checkOutput("load_first_ld", fpu_ld, 1'b0);
            checkOutput("load_inp", fpu_inp, ei.inp);
          end else begin
            checkOutput("issue_addr2", fpu_addr2, ei.a2);
            checkOutput("issue_addr3", fpu_addr3, ei.a3);
          end
        end
      end
      if (prev_en && !prev_ld && prev_opc == 3'b100)
        checkOutput("load_write", {fpu_enable, fpu_ld, fpu_addr1, fpu_inp}, {2'b11, prev_a1, prev_inp});
      if (prev_en && prev_ld)
        checkOutput("load_end_gap", fpu_enable, 1'b0);
      if (rsp_valid)
        checkOutput("rsp_enable_low", fpu_enable, 1'b0);
      if (prev_rsp_valid && !prev_rsp_ready)
        checkOutput("rsp_hold", {rsp_valid, rsp_data, rsp_flags, rsp_timeout},
                    {1'b1, prev_rsp_data, prev_rsp_flags, prev_tmo});
      if (rsp_valid && rsp_ready) begin
        rsp_count++;
        last_rsp_data  = rsp_data;
        last_rsp_flags = rsp_flags;
        if (rsp_q.size() == 0) begin
          checkOutput("unexpected_rsp", 64'd1, 64'd0);
        end else begin
          er = rsp_q.pop_front();
          checkOutput("rsp_data", rsp_data, er.data);
          checkOutput("rsp_flags", rsp_flags, er.flags);
          checkOutput("rsp_timeout", rsp_timeout, er.tmo);
        end
      end
      prev_en = fpu_enable; prev_ld = fpu_ld; prev_opc = fpu_opcode;
      prev_a1 = fpu_addr1; prev_inp = fpu_inp;
      prev_rsp_valid = rsp_valid; prev_rsp_ready = rsp_ready;
      prev_rsp_data = rsp_data; prev_rsp_flags = rsp_flags; prev_tmo = rsp_timeout;
    end
  end

  // Offers one command (entered at posedge+1) and returns once it is accepted
  task automatic applyStimulus(input logic [2:0] op, input logic [4:0] s1, input logic [4:0] s2,
                               input logic [4:0] d, input logic [31:0] data);
    logic accepted = 1'b0;
    int   waited = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_src1 = s1; cmd_src2 = s2; cmd_dst = d; cmd_data = data;
    while (!accepted && waited < 200) begin
      @(negedge clk);
      accepted = cmd_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    cmd_valid = 1'b0;
    if (!accepted) checkOutput("cmd_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic waitRsp(input int target);
    for (int i = 0; i < 300 && rsp_count < target; i++) begin
      @(negedge clk);
      #1;
    end
    checkOutput("rsp_arrived", rsp_count >= target, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic waitValid();
    for (int i = 0; i < 300 && !rsp_valid; i++) begin
      @(negedge clk);
      #1;
    end
    checkOutput("rsp_valid_seen", rsp_valid, 1'b1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base_i, base_r, base_a, n;
    cmd_valid = 1'b0; cmd_op = '0; cmd_src1 = '0; cmd_src2 = '0; cmd_dst = '0; cmd_data = '0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    checkOutput("reset_state",
                {cmd_ready, rsp_valid, rsp_timeout, busy, fpu_enable, fpu_ld, fpu_opcode, fpu_addr1, fpu_inp, rsp_data, rsp_flags},
                {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b0, 5'b0, 32'h0, 32'h0, 8'h0});
    rstp = 1'b1;
    @(posedge clk);
    #1;

    // Reset in the middle of an operation the fpu never finishes
    fpu_mute = 1'b1;
    applyStimulus(3'b000, 5'd0, 5'd1, 5'd2, 32'h0);
    for (int i = 0; i < 50 && !fpu_enable; i++) begin
      @(negedge clk);
      #1;
    end
    checkOutput("op_run_entered", fpu_enable, 1'b1);
    repeat (3) @(posedge clk);
    #3;
    rstp = 1'b0;
    #1;
    checkOutput("async_reset", {fpu_enable, rsp_valid, cmd_ready, busy}, 4'b0010);
    repeat (2) @(posedge clk);
    #3;
    rstp = 1'b1;
    fpu_mute = 1'b0;
    @(posedge clk);
    #1;

    // Two loads then an add: three separate enable pulses
    rsp_ready = 1'b1;
    base_i = issue_count;
    base_r = rsp_count;
    applyStimulus(3'b100, 5'd0, 5'd0, 5'd0, 32'h3F800000);
    applyStimulus(3'b100, 5'd1, 5'd0, 5'd0, 32'h40000000);
    applyStimulus(3'b000, 5'd0, 5'd1, 5'd2, 32'h0);
    waitRsp(base_r + 1);
    checkOutput("add_result", last_rsp_data, 32'h40400000);
    checkOutput("add_flags", last_rsp_flags, 8'h00);
    checkOutput("add_issue_pulses", issue_count - base_i, 3);

    // Divide by zero with the consumer stalled for 10 cycles
    rsp_ready = 1'b0;
    base_r = rsp_count;
    applyStimulus(3'b100, 5'd3, 5'd0, 5'd0, 32'h0);
    applyStimulus(3'b011, 5'd2, 5'd3, 5'd4, 32'h0);
    waitValid();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      checkOutput("div_hold", {rsp_valid, fpu_enable, rsp_data}, {1'b1, 1'b0, 32'h7F800000});
      checkOutput("div_zero_flag", rsp_flags[FLAG_DIV_ZERO], 1'b1);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    waitRsp(base_r + 1);

    // Illegal opcode is dropped; the following command still runs
    base_i = issue_count;
    base_r = rsp_count;
    applyStimulus(3'b110, 5'd1, 5'd1, 5'd1, 32'hDEADBEEF);
    applyStimulus(3'b001, 5'd1, 5'd0, 5'd5, 32'h0);
    waitRsp(base_r + 1);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("illegal_no_issue", issue_count - base_i, 1);
    checkOutput("illegal_no_rsp", rsp_count - base_r, 1);
    checkOutput("sub_result", last_rsp_data, 32'h00800000);

    // Fill the FIFO while the FSM is stuck in RSP
    rsp_ready = 1'b0;
    base_r = rsp_count;
    applyStimulus(3'b010, 5'd0, 5'd1, 5'd6, 32'h0);
    waitValid();
    applyStimulus(3'b100, 5'd8, 5'd0, 5'd0, 32'd5);
    applyStimulus(3'b100, 5'd9, 5'd0, 5'd0, 32'd7);
    applyStimulus(3'b010, 5'd8, 5'd9, 5'd10, 32'h0);
    applyStimulus(3'b000, 5'd8, 5'd9, 5'd11, 32'h0);
    checkOutput("fifo_full_ready", cmd_ready, 1'b0);
    base_a = accept_count;
    fork
      applyStimulus(3'b001, 5'd9, 5'd8, 5'd12, 32'h0);
      begin
        repeat (5) @(posedge clk);
        #2;
        checkOutput("fifth_held", accept_count - base_a, 0);
        rsp_ready = 1'b1;
      end
    join
    waitRsp(base_r + 4);
    checkOutput("fifth_result", last_rsp_data, 32'd2);

`ifdef FPU_SEQ_TIMEOUT_EN
    // Watchdog abort when the fpu never signals done
    fpu_mute = 1'b1;
    expect_timeout = 1'b1;
    rsp_ready = 1'b0;
    base_r = rsp_count;
    applyStimulus(3'b000, 5'd0, 5'd1, 5'd13, 32'h0);
    for (int i = 0; i < 50 && !fpu_enable; i++) begin
      @(negedge clk);
      #1;
    end
    n = 0;
    while (!rsp_valid && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("timeout_cycles", n, 64);
    checkOutput("timeout_payload", {rsp_timeout, rsp_data, rsp_flags}, {1'b1, 32'h0, 8'h0});
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    waitRsp(base_r + 1);
    fpu_mute = 1'b0;
    expect_timeout = 1'b0;
`else
    n = 0;
`endif

    repeat (5) @(posedge clk);
    #1;
    checkOutput("drained", {busy, rsp_valid, fpu_enable}, 3'b000);
    checkOutput("issues_left", issue_q.size(), 0);
    checkOutput("responses_left", rsp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
